// File: rtl/alu_frame_sequencer.sv
// alu_frame_sequencer
//
// Frame controller wrapped around the combinational eight_bit_alu. A frame
// arrives byte-serially from upstream:
//   byte 0: opcode  -- [3:0] ALU function code, [MSB] CHAIN, bits between reserved
//   byte 1: operand A (skipped when CHAIN is set; A then reuses the accumulator)
//   byte 2: operand B
// The sequencer drives the ALU operands and function code, waits one full
// cycle for the ALU to settle, then captures the result into the
// result/accumulator register. The result is offered downstream on a
// valid/ready handshake.
//
// Ports:
//   clk_i        clock; all state updates on its rising edge
//   rst_i        asynchronous, active-high reset
//   in_data_i    frame byte from upstream
//   in_valid_i   in_data_i holds a valid byte
//   in_ready_o   sequencer can accept a byte this cycle
//   a8_o         ALU operand A
//   b8_o         ALU operand B
//   f8_o         ALU function code
//   y8_i         ALU result
//   res8_o       captured result, also the accumulator for chained frames
//   res_valid_o  res8_o holds a new, unconsumed result
//   res_ready_i  downstream accepts the result
//   busy_o       a frame is in progress or a result is pending

module alu_frame_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FUNC_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,

  output logic [DATA_WIDTH-1:0] a8_o,
  output logic [DATA_WIDTH-1:0] b8_o,
  output logic [FUNC_WIDTH-1:0] f8_o,
  input  logic [DATA_WIDTH-1:0] y8_i,

  output logic [DATA_WIDTH-1:0] res8_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,

  output logic                  busy_o
);

  // CHAIN lives in the opcode MSB (bit 7 at the default width).
  localparam int unsigned ChainBit = DATA_WIDTH - 1;

  // Function code that makes the ALU output all zeros; used as the idle code.
  localparam logic [FUNC_WIDTH-1:0] FuncAllZero = '0;

  typedef enum logic [2:0] {
    StGetOp,
    StGetA,
    StGetB,
    StExec,
    StHold
  } state_e;

  state_e state_q;
  logic   chain_q;
  logic   xfer;

  // Handshake outputs are decoded from registered state only, so upstream
  // never sees a combinational path from in_valid_i to in_ready_o.
  always_comb begin
    in_ready_o = 1'b0;
    unique case (state_q)
      StGetOp, StGetA, StGetB: in_ready_o = 1'b1;
      default:                 in_ready_o = 1'b0;
    endcase
  end

  assign busy_o = (state_q != StGetOp);
  assign xfer   = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StGetOp;
      a8_o        <= '0;
      b8_o        <= '0;
      f8_o        <= FuncAllZero;
      res8_o      <= '0;
      res_valid_o <= 1'b0;
      chain_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StGetOp: begin
          if (xfer) begin
            f8_o    <= in_data_i[FUNC_WIDTH-1:0];
            chain_q <= in_data_i[ChainBit];
            if (in_data_i[ChainBit]) begin
              // Chained: operand A is the previous result, so no A byte follows.
              a8_o    <= res8_o;
              state_q <= StGetB;
            end else begin
              state_q <= StGetA;
            end
          end
        end

        StGetA: begin
          if (xfer) begin
            a8_o    <= in_data_i;
            state_q <= StGetB;
          end
        end

        StGetB: begin
          if (xfer) begin
            b8_o    <= in_data_i;
            state_q <= StExec;
          end
        end

        // Operands have been stable for this whole cycle; capture at its end.
        StExec: begin
          res8_o      <= y8_i;
          res_valid_o <= 1'b1;
          state_q     <= StHold;
        end

        StHold: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            state_q     <= StGetOp;
          end
        end

        default: begin
          state_q     <= StGetOp;
          res_valid_o <= 1'b0;
        end
      endcase
    end
  end

  // The chain flag is retained for observability only; reserved opcode bits
  // are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{chain_q, in_data_i[ChainBit-1:FUNC_WIDTH]};

  // A result is pending exactly while the sequencer sits in HOLD.
  valid_matches_hold_a: assert property (
    @(posedge clk_i) disable iff (rst_i) res_valid_o == (state_q == StHold)
  );

  // Nothing is accepted while executing or holding a result.
  no_ready_when_busy_a: assert property (
    @(posedge clk_i) disable iff (rst_i)
      (state_q == StExec || state_q == StHold) |-> !in_ready_o
  );

endmodule
